// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//
// PS/2 device-to-host receiver with a glitch filter on ps2c, start/stop/odd-
// parity checking, an inter-bit watchdog and a small first-word-fall-through
// FIFO. It sits between the (already synchronised) PS/2 pins and the
// keyboard scan-code decoder. The decoder pops bytes at its own pace.
//
// Parameters
//   FILTER_LEN  : ps2c filter length in clk cycles (2..16)
//   TIMEOUT_CYC : max clk cycles allowed between falling edges in a frame
//   ADDR_W      : FIFO address width, depth = 2**ADDR_W (ADDR_W >= 1)
//
// Ports
//   clk            : system clock
//   reset          : asynchronous, active-low reset (0 = reset)
//   ps2d           : PS/2 data line
//   ps2c           : PS/2 clock line
//   rx_en          : enables detection of a new start bit
//   rd             : pop the FIFO head (ignored when empty)
//   dout           : FIFO head data, 0 when empty
//   dout_perr      : parity-error flag of the head entry, 0 when empty
//   empty / full   : FIFO status
//   rx_done_tick   : 1-cycle pulse, frame written to the FIFO
//   frame_err_tick : 1-cycle pulse, frame dropped (bad start/stop bit)
//   timeout_tick   : 1-cycle pulse, frame aborted by the watchdog
//   ovf_tick       : 1-cycle pulse, good frame dropped because FIFO full
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000,
   parameter int ADDR_W      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2d,
   input  logic       ps2c,
   input  logic       rx_en,
   input  logic       rd,
   output logic [7:0] dout,
   output logic       dout_perr,
   output logic       empty,
   output logic       full,
   output logic       rx_done_tick,
   output logic       frame_err_tick,
   output logic       timeout_tick,
   output logic       ovf_tick
);

   // Timer must hold TIMEOUT_CYC-1.
   localparam int                 TIMER_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
   localparam int                 DEPTH     = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE,   // waiting for a start bit
      DPS,    // data, parity, stop bits
      CHECK   // one-cycle frame validation and FIFO write
   } state_t;

   // ------------------------------------------------------------------------
   // ps2c glitch filter
   // ------------------------------------------------------------------------
   logic [FILTER_LEN-1:0] filter_reg;
   logic                  f_reg;
   logic                  f_next;
   logic                  fall_edge;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filter_reg <= '0;
         f_reg      <= 1'b0;
      end else begin
         filter_reg <= {ps2c, filter_reg[FILTER_LEN-1:1]};
         f_reg      <= f_next;
      end
   end

   // The filtered clock only changes once ps2c has been stable for the whole
   // filter window; anything shorter leaves f_reg untouched.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      f_next = f_reg;
      if (&filter_reg) begin
         f_next = 1'b1;
      end else if (~|filter_reg) begin
         f_next = 1'b0;
      end
   end

   assign fall_edge = f_reg & ~f_next;

   // ------------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------------
   state_t             state;
   logic [3:0]         n_reg;
   logic [10:0]        b_reg;
   logic [TIMER_W-1:0] timer;
   logic               frame_ok;
   logic               perr;
   logic               push;
   logic               pop;

   // b_reg[0] = start, b_reg[8:1] = data, b_reg[9] = parity, b_reg[10] = stop.
   assign frame_ok = ~b_reg[0] & b_reg[10];

   // Odd parity over data plus parity bit: an even count of ones is an error.
   assign perr = ~^b_reg[9:1];

   // The write happens at the end of the CHECK cycle, in the same edge as a
   // concurrent pop, so a full FIFO with rd asserted accepts the frame.
   assign push = (state == CHECK) & frame_ok & (~full | rd);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         n_reg          <= '0;
         b_reg          <= '0;
         timer          <= '0;
         rx_done_tick   <= 1'b0;
         frame_err_tick <= 1'b0;
         timeout_tick   <= 1'b0;
         ovf_tick       <= 1'b0;
      end else begin
         rx_done_tick   <= 1'b0;
         frame_err_tick <= 1'b0;
         timeout_tick   <= 1'b0;
         ovf_tick       <= 1'b0;

         case (state)
            IDLE: begin
               if (fall_edge && rx_en) begin
                  b_reg <= {ps2d, b_reg[10:1]};
                  n_reg <= 4'd9;
                  timer <= '0;
                  state <= DPS;
               end
            end

            // rx_en is deliberately not looked at here: once a frame has
            // started it runs to completion or to the watchdog.
            DPS: begin
               if (fall_edge) begin
                  b_reg <= {ps2d, b_reg[10:1]};
                  timer <= '0;
                  if (n_reg == 4'd0) begin
                     state <= CHECK;
                  end else begin
                     n_reg <= n_reg - 4'd1;
                  end
               end else if (timer == TIMER_MAX) begin
                  timeout_tick <= 1'b1;
                  timer        <= '0;
                  state        <= IDLE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            CHECK: begin
               state <= IDLE;
               if (!frame_ok) begin
                  frame_err_tick <= 1'b1;
               end else if (push) begin
                  rx_done_tick <= 1'b1;
               end else begin
                  ovf_tick <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // First-word-fall-through FIFO
   // ------------------------------------------------------------------------
   // Each entry is {perr, data}.
   logic [8:0]      mem [DEPTH];
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [8:0]      head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign pop   = rd & ~empty;

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, and an unreset array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[ADDR_W-1:0]] <= {perr, b_reg[8:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Head is shown combinationally; masked to zero while the FIFO is empty.
   assign head      = mem[rd_ptr[ADDR_W-1:0]];
   assign dout      = empty ? 8'h00 : head[7:0];
   assign dout_perr = ~empty & head[8];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
//
// Directed bench for ps2_rx_fifo. PS/2 frames are driven bit by bit with a
// 100-cycle ps2c period (ps2d set mid-high phase, ps2c low for 50 cycles).
// Expected data, parity flags, tick counts and latencies are hand-derived.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

   localparam int FILTER_LEN  = 4;
   localparam int TIMEOUT_CYC = 300;
   localparam int ADDR_W      = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2d;
   logic       ps2c;
   logic       rx_en;
   logic       rd;
   logic [7:0] dout;
   logic       dout_perr;
   logic       empty;
   logic       full;
   logic       rx_done_tick;
   logic       frame_err_tick;
   logic       timeout_tick;
   logic       ovf_tick;

   ps2_rx_fifo #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ps2d          (ps2d),
      .ps2c          (ps2c),
      .rx_en         (rx_en),
      .rd            (rd),
      .dout          (dout),
      .dout_perr     (dout_perr),
      .empty         (empty),
      .full          (full),
      .rx_done_tick  (rx_done_tick),
      .frame_err_tick(frame_err_tick),
      .timeout_tick  (timeout_tick),
      .ovf_tick      (ovf_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Free-running cycle counter, read on negedges.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Tick monitor (samples on negedges).
   int   n_done  = 0;
   int   n_ferr  = 0;
   int   n_to    = 0;
   int   n_ovf   = 0;
   int   n_multi = 0;
   int   done_cyc = 0;
   int   to_cyc   = 0;
   logic prev_done = 1'b0;
   logic empty_after_done = 1'bx;

   always @(negedge clk) begin
      if (prev_done) empty_after_done = empty;
      prev_done = (rx_done_tick === 1'b1);
      if (rx_done_tick === 1'b1) begin
         n_done++;
         done_cyc = cyc;
      end
      if (frame_err_tick === 1'b1) n_ferr++;
      if (timeout_tick === 1'b1) begin
         n_to++;
         to_cyc = cyc;
      end
      if (ovf_tick === 1'b1) n_ovf++;
      if ($countones({rx_done_tick, frame_err_tick, timeout_tick, ovf_tick}) > 1) n_multi++;
   end

   int s_done, s_ferr, s_to, s_ovf;
   int last_fall_cyc = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_done = n_done;
      s_ferr = n_ferr;
      s_to   = n_to;
      s_ovf  = n_ovf;
   endtask

   task automatic check_deltas(input string tag, input int d_done, input int d_ferr,
                               input int d_to, input int d_ovf);
      check({tag, "_done"}, n_done - s_done, d_done);
      check({tag, "_ferr"}, n_ferr - s_ferr, d_ferr);
      check({tag, "_to"},   n_to - s_to,     d_to);
      check({tag, "_ovf"},  n_ovf - s_ovf,   d_ovf);
   endtask

   // One PS/2 bit. With pop_in_check, rd is pulsed during the CHECK cycle,
   // which is FILTER_LEN+1 cycles after ps2c is driven low on the stop bit.
   task automatic send_bit(input logic bitv, input bit pop_in_check);
      ps2d = bitv;
      tick(25);
      ps2c = 1'b0;
      last_fall_cyc = cyc;
      if (pop_in_check) begin
         tick(FILTER_LEN + 1);
         check("full_in_check", full, 1);
         rd = 1'b1;
         tick(1);
         rd = 1'b0;
         check("full_after_push_pop", full, 1);
         tick(50 - FILTER_LEN - 2);
      end else begin
         tick(50);
      end
      ps2c = 1'b1;
      tick(25);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic start, input logic par,
                             input logic stop, input int nbits, input bit pop_last);
      logic [10:0] fr;
      fr = {stop, par, data, start};
      for (int i = 0; i < nbits; i++) send_bit(fr[i], pop_last && (i == 10));
   endtask

   function automatic logic odd_par(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic send_good(input logic [7:0] d);
      send_frame(d, 1'b0, odd_par(d), 1'b1, 11, 1'b0);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp_d, input logic exp_p);
      check({tag, "_empty"}, empty, 0);
      check({tag, "_dout"}, dout, exp_d);
      check({tag, "_perr"}, dout_perr, exp_p);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      ps2c  = 1'b1;
      ps2d  = 1'b1;
      rx_en = 1'b1;
      rd    = 1'b0;
      tick(3);

      // Reset state
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_dout", dout, 8'h00);
      check("rst_perr", dout_perr, 0);
      check("rst_ticks", {rx_done_tick, frame_err_tick, timeout_tick, ovf_tick}, 4'b0000);
      reset = 1'b1;
      tick(FILTER_LEN + 5);

      // 1: 0x1C, parity 0, good
      snap();
      send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 11, 1'b0);
      check_deltas("t1", 1, 0, 0, 0);
      check("t1_latency", done_cyc - last_fall_cyc, FILTER_LEN + 2);
      check("t1_empty_after_done", empty_after_done, 0);
      pop_check("t1", 8'h1C, 1'b0);
      check("t1_empty_after_pop", empty, 1);
      check("t1_dout_after_pop", dout, 8'h00);

      // rx_en = 0: edges ignored
      rx_en = 1'b0;
      snap();
      send_good(8'h1C);
      check_deltas("rxen0", 0, 0, 0, 0);
      check("rxen0_empty", empty, 1);
      rx_en = 1'b1;

      // 2: 0x1C with parity 1 -> stored with parity error
      snap();
      send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11, 1'b0);
      check_deltas("t2", 1, 0, 0, 0);
      pop_check("t2", 8'h1C, 1'b1);

      // 3: bad stop bit, then bad start bit
      snap();
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, 11, 1'b0);
      check_deltas("t3_stop", 0, 1, 0, 0);
      check("t3_stop_empty", empty, 1);
      snap();
      send_frame(8'h55, 1'b1, 1'b1, 1'b1, 11, 1'b0);
      check_deltas("t3_start", 0, 1, 0, 0);
      check("t3_start_empty", empty, 1);

      // 4: stalled frame -> watchdog, then a valid frame
      snap();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 4, 1'b0);
      tick(TIMEOUT_CYC + 40);
      check_deltas("t4_stall", 0, 0, 1, 0);
      check("t4_to_latency", to_cyc - last_fall_cyc, FILTER_LEN + 1 + TIMEOUT_CYC);
      check("t4_empty", empty, 1);
      snap();
      send_good(8'hF0);
      check_deltas("t4_next", 1, 0, 0, 0);
      pop_check("t4", 8'hF0, 1'b0);

      // 5: overflow, ordering, push+pop while full
      snap();
      for (int i = 1; i <= 5; i++) send_good(8'(i));
      check_deltas("t5_fill", 4, 0, 0, 1);
      check("t5_full", full, 1);
      pop_check("t5_p1", 8'h01, 1'b0);
      check("t5_not_full", full, 0);
      pop_check("t5_p2", 8'h02, 1'b0);
      pop_check("t5_p3", 8'h03, 1'b0);
      pop_check("t5_p4", 8'h04, 1'b0);
      check("t5_empty", empty, 1);
      for (int i = 7; i <= 10; i++) send_good(8'(i));
      check("t5_refull", full, 1);
      snap();
      send_frame(8'h06, 1'b0, odd_par(8'h06), 1'b1, 11, 1'b1);
      check_deltas("t5_pp", 1, 0, 0, 0);
      check("t5_pp_full", full, 1);
      pop_check("t5_q1", 8'h08, 1'b0);
      pop_check("t5_q2", 8'h09, 1'b0);
      pop_check("t5_q3", 8'h0A, 1'b0);
      pop_check("t5_q4", 8'h06, 1'b0);
      check("t5_q_empty", empty, 1);

      // 6: reset mid-frame with entries queued, glitch rejection
      send_good(8'h11);
      send_good(8'h22);
      send_frame(8'h33, 1'b0, 1'b1, 1'b1, 3, 1'b0);
      check("t6_pre_empty", empty, 0);
      reset = 1'b0;
      #1;
      check("t6_rst_empty_async", empty, 1);
      tick(1);
      reset = 1'b1;
      check("t6_empty", empty, 1);
      check("t6_full", full, 0);
      check("t6_dout", dout, 8'h00);
      check("t6_perr", dout_perr, 0);
      check("t6_ticks", {rx_done_tick, frame_err_tick, timeout_tick, ovf_tick}, 4'b0000);
      tick(FILTER_LEN + 5);
      snap();
      ps2c = 1'b0;
      tick(FILTER_LEN - 1);
      ps2c = 1'b1;
      tick(60);
      check_deltas("t6_glitch", 0, 0, 0, 0);
      snap();
      send_good(8'h5A);
      check_deltas("t6_next", 1, 0, 0, 0);
      pop_check("t6", 8'h5A, 1'b0);
      check("t6_final_empty", empty, 1);

      check("one_tick_per_cycle", n_multi, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
